ctrl_multiciclo: RTL and testbench

Multicycle MIPS main control unit: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and write-back, and drives the datapath strobes. It is the producer side of the `ALUOp` interface consumed by the ALU control decoder. It emits `ALUOp` = 00 (add), 01 (subtract) or 10 (R-type, decode by funct) per state. It sits between the instruction register (opcode/funct inputs) and the datapath muxes, register file, memory and PC.

---
 rtl/ctrl_multiciclo_pkg.sv | 36 +++
 rtl/ctrl_multiciclo.sv | 143 ++++++++++++++
 tb/tb_ctrl_multiciclo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: opcodes, ALUOp codes and
// the 4-bit state codes exposed on the debug port.
package ctrl_multiciclo_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FunctJr = 6'h08;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;

  typedef enum logic [3:0] {
    StRst    = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StREx    = 4'd7,
    StRWb    = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StJr     = 4'd11,
    StAddiEx = 4'd12,
    StAddiWb = 4'd13
  } state_e;

endpackage

// File: rtl/ctrl_multiciclo.sv
// Moore main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back and drives the datapath strobes from the state alone.
module ctrl_multiciclo
  import ctrl_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  state_e state_q, state_d;

  // The zero flag is qualified by PCWriteCond/PCWriteCondNe in the datapath's PC-load logic.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRst;
    case (state_q)
      StRst:   state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:   state_d = StMemAdr;
          OpRtype:      state_d = (funct == FunctJr) ? StJr : StREx;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi:       state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StREx:    state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StJr:     state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      default:  state_d = StRst;
    endcase
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = AluOpAdd;
    PCSource      = 2'b00;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      // Speculative branch target (PC + imm<<2) parked in ALUOut.
      StDecode: ALUSrcB = 2'b11;
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StREx: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluOpRtype;
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      // Only output with an input dependency: beq vs bne picks the conditional strobe.
      StBranch: begin
        ALUSrcA       = 1'b1;
        ALUOp         = AluOpSub;
        PCSource      = 2'b01;
        PCWriteCond   = (opcode == OpBeq);
        PCWriteCondNe = (opcode == OpBne);
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StJr: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      StAddiWb: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Scoreboard bench for ctrl_multiciclo: an instruction-level model expands each opcode into
// its expected per-cycle control word; a monitor compares every DUT cycle against the queue.
module tb_ctrl_multiciclo;
  import ctrl_multiciclo_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  rec_t  exp_q[$];
  string tag_q[$];
  rec_t  plan[$];

  always #5 clk = ~clk;

  ctrl_multiciclo dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemtoReg     (MemtoReg),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .PCSource     (PCSource),
    .state        (state)
  );

  function automatic rec_t mk(input state_e s, input ctl_t c);
    rec_t r;
    r.st = s;
    r.c  = c;
    return r;
  endfunction

  // Instruction-level reference: opcode/funct -> ordered list of (state, control word).
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    plan = {};
    c = '0; c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1;
    plan.push_back(mk(StFetch, c));
    c = '0; c.alu_src_b = 2'b11;
    plan.push_back(mk(StDecode, c));
    if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
      plan.push_back(mk(StMemAdr, c));
      if (op == 6'h23) begin
        c = '0; c.mem_read = 1; c.iord = 1;
        plan.push_back(mk(StMemRd, c));
        c = '0; c.reg_write = 1; c.mem_to_reg = 1;
        plan.push_back(mk(StMemWb, c));
      end else begin
        c = '0; c.mem_write = 1; c.iord = 1;
        plan.push_back(mk(StMemWr, c));
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b11;
      plan.push_back(mk(StJr, c));
    end else if (op == 6'h00) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b10;
      plan.push_back(mk(StREx, c));
      c = '0; c.reg_write = 1; c.reg_dst = 1;
      plan.push_back(mk(StRWb, c));
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01;
      c.pc_write_cond    = (op == 6'h04);
      c.pc_write_cond_ne = (op == 6'h05);
      plan.push_back(mk(StBranch, c));
    end else if (op == 6'h02) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b10;
      plan.push_back(mk(StJump, c));
    end else if (op == 6'h08) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
      plan.push_back(mk(StAddiEx, c));
      c = '0; c.reg_write = 1;
      plan.push_back(mk(StAddiWb, c));
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(mk(StRst, '0));
      tag_q.push_back(tag);
      @(posedge clk);
    end
  endtask

  // abort_at >= 1 asserts reset in place of plan step abort_at (mid-instruction).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at,
                           input int rst_cycles, input string tag);
    build(op, fn);
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abort_at) begin
        do_reset(rst_cycles, {tag, "_rst"});
        return;
      end
      @(negedge clk);
      rst = 1'b0;
      if (i == 1) begin
        opcode = op;
        funct  = fn;
      end
      exp_q.push_back(plan[i]);
      tag_q.push_back($sformatf("%s_c%0d", tag, i));
      @(posedge clk);
    end
  endtask

  initial begin : monitor
    rec_t  e, a;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.st = state;
        a.c  = '{PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                   t, a.st, a.c, e.st, e.c);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0] op, fn;
    int         pick, ab, len;
    do_reset(2, "reset");
    run_instr(6'h23, 6'h00, -1, 0, "lw");
    run_instr(6'h2B, 6'h00, -1, 0, "sw");
    run_instr(6'h00, 6'h20, -1, 0, "add");
    run_instr(6'h00, 6'h08, -1, 0, "jr");
    run_instr(6'h04, 6'h00, -1, 0, "beq");
    run_instr(6'h05, 6'h00, -1, 0, "bne");
    run_instr(6'h02, 6'h00, -1, 0, "j");
    run_instr(6'h08, 6'h00, -1, 0, "addi");
    run_instr(6'h3F, 6'h00, -1, 0, "illegal");
    // Reset held two cycles while in R_EX, then a clean restart.
    run_instr(6'h00, 6'h20, 3, 2, "add_abort");
    run_instr(6'h23, 6'h00, -1, 0, "lw_after_rst");
    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 8);
      fn   = 6'($urandom_range(0, 63));
      case (pick)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: begin op = 6'h00; fn = 6'h08; end
        4: op = 6'h04;
        5: op = 6'h05;
        6: op = 6'h02;
        7: op = 6'h08;
        default: begin
          do op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B});
        end
      endcase
      build(op, fn);
      len = plan.size();
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      run_instr(op, fn, ab, int'($urandom_range(1, 2)), $sformatf("rnd%0d_op%02h", n, op));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
